// File: rtl/lsu_align_rmw.sv
// lsu_align_rmw: word-aligned load/store unit with sub-word read-modify-write stores
module lsu_align_rmw #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  typedef enum logic [2:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR, ST_WR, RESP} state_t;
  state_t state, state_nx;
  logic [DM_ADDRESS-1:0] a_q, a_sel;
  logic [2:0] f_q;
  logic [15:0] wd_q, half_v;
  logic [7:0] byte_v;
  logic [DATA_W-1:0] wdata_q, rd_q, ld_val, merged;
  logic err_q, accept, is_ld, is_st, bad_f, mis, bad;
  assign is_ld = MemRead & ~MemWrite;
  assign is_st = MemWrite & ~MemRead;
  assign bad_f = is_ld ? (Funct3[1:0] == 2'b11 || Funct3[2:1] == 2'b11) :
                 is_st ? (Funct3[2] || Funct3[1:0] == 2'b11) : 1'b1;
  assign mis = Funct3[1] ? |addr[1:0] : Funct3[0] & addr[0];
  assign bad = bad_f | mis;
  assign accept = rst_n && state == IDLE && req_valid;
  // the read for loads and sub-word stores is issued in the accept cycle itself
  assign a_sel = accept ? addr : a_q;
  assign req_ready = rst_n && state == IDLE;
  assign mem_re = accept && !bad && (is_ld || !Funct3[1]);
  assign mem_we = rst_n && (state == RMW_WR || state == ST_WR);
  assign mem_addr = {a_sel[DM_ADDRESS-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign resp_valid = rst_n && state == RESP;
  assign err = resp_valid && err_q;
  assign rd = rd_q;
  assign byte_v = mem_rdata[{a_q[1:0], 3'b000} +: 8];
  assign half_v = mem_rdata[{a_q[1], 4'b0000} +: 16];
  assign ld_val = f_q[1] ? mem_rdata :
                  f_q[0] ? {{16{~f_q[2] & half_v[15]}}, half_v} :
                           {{24{~f_q[2] & byte_v[7]}}, byte_v};
  always_comb begin
    merged = mem_rdata;
    if (f_q[0]) merged[{a_q[1], 4'b0000} +: 16] = wd_q;
    else merged[{a_q[1:0], 3'b000} +: 8] = wd_q[7:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = bad ? RESP : is_ld ? LD_WAIT : Funct3[1] ? ST_WR : RMW_RD;
      LD_WAIT, RMW_WR, ST_WR: state_nx = RESP;
      RMW_RD: state_nx = RMW_WR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      f_q <= '0;
      wd_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= addr;
        f_q <= Funct3;
        wd_q <= wd[15:0];
        err_q <= bad;
      end
      if (accept && bad) rd_q <= '0;
      if (state == LD_WAIT) rd_q <= ld_val;
      if (accept && !bad && is_st && Funct3[1]) wdata_q <= wd;
      if (state == RMW_RD) wdata_q <= merged;
    end
  end
endmodule

// File: tb/tb_lsu_align_rmw.sv
// tb_lsu_align_rmw: byte-level reference model checked every cycle, plus directed literal checks
module tb_lsu_align_rmw;
  logic clk = 0, rst_n = 0, req_valid = 0, MemRead = 0, MemWrite = 0;
  logic [2:0] Funct3 = 0;
  logic [8:0] addr = 0;
  logic [31:0] wd = 0, mem_rdata = 0;
  logic req_ready, resp_valid, err, mem_re, mem_we;
  logic [31:0] rd, mem_wdata;
  logic [8:0] mem_addr;
  int checks = 0, failures = 0;
  logic [31:0] ram [128];
  logic [7:0] mbyte [512];
  logic armed = 0, rst_edge = 0, minit = 0;
  int t = -1, resp_cnt = 0;
  logic p_err = 0, p_ld = 0, p_wr = 0;
  logic [31:0] p_rd = 0, p_word = 0, m_rd = 0;
  logic [8:0] p_wa = 0;

  lsu_align_rmw dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
    .resp_valid(resp_valid), .rd(rd), .err(err), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int w);
    return w == 16 ? 32'h8899AABB : 32'(w * 32'h01010101);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // data memory: synchronous read, one word port
  always @(posedge clk) begin
    if (!armed) for (int w = 0; w < 128; w++) ram[w] <= init_word(w);
    if (mem_we) ram[mem_addr[8:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[8:2]];
    if (!rst_n) armed <= 1'b1;
    rst_edge <= !rst_n;
  end

  always @(negedge clk) if (resp_valid) resp_cnt++;

  // reference model: byte-addressed memory and a countdown to the response cycle
  always @(negedge clk) begin
    logic ld, st, ok;
    int nb, off;
    logic [31:0] v;
    logic [7:0] b [4];
    if (!minit) begin
      for (int w = 0; w < 128; w++) for (int k = 0; k < 4; k++) mbyte[w*4+k] = 8'(init_word(w) >> (8*k));
      minit = 1;
    end
    if (armed) begin
      if (rst_edge) begin
        m_rd = 0;
        t = -1;
      end
      if (!rst_n) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_err", err, 0);
        if (rst_edge) begin
          chk("rst_rd", rd, 0);
          chk("rst_addr", 32'(mem_addr), 0);
          chk("rst_wdata", mem_wdata, 0);
        end
        t = -1;
      end else if (t < 0) begin
        chk("idle_ready", req_ready, 1);
        chk("idle_resp", resp_valid, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_err", err, 0);
        if (req_valid) begin
          ld = MemRead && !MemWrite;
          st = MemWrite && !MemRead;
          nb = 1 << Funct3[1:0];
          ok = ((ld && Funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                (st && Funct3 inside {3'd0, 3'd1, 3'd2})) && (int'(addr) % nb == 0);
          p_wa = {addr[8:2], 2'b00};
          off = int'(addr[1:0]);
          v = 0;
          for (int k = 0; k < 4; k++) b[k] = mbyte[int'(p_wa) + k];
          if (ld && ok) begin
            for (int k = 0; k < nb; k++) v = v | (32'(b[off+k]) << (8*k));
            if (nb < 4 && !Funct3[2] && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
          end
          if (st && ok) for (int k = 0; k < nb; k++) b[off+k] = wd[8*k +: 8];
          p_word = {b[3], b[2], b[1], b[0]};
          p_rd = v;
          p_err = !ok;
          p_ld = ld;
          p_wr = ok && st;
          chk("accept_re", mem_re, ok && (ld || nb != 4));
          if (ok && (ld || nb != 4)) chk("accept_addr", 32'(mem_addr), 32'(p_wa));
          t = !ok ? 1 : (ld || nb == 4) ? 2 : 3;
        end else chk("idle_re", mem_re, 0);
      end else begin
        t--;
        chk("busy_ready", req_ready, 0);
        chk("busy_re", mem_re, 0);
        chk("busy_resp", resp_valid, t == 0);
        chk("busy_err", err, t == 0 && p_err);
        chk("busy_we", mem_we, t == 1 && p_wr);
        if (t == 1 && p_wr) begin
          chk("wr_addr", 32'(mem_addr), 32'(p_wa));
          chk("wr_data", mem_wdata, p_word);
          for (int k = 0; k < 4; k++) mbyte[int'(p_wa) + k] = p_word[8*k +: 8];
        end
        if (t == 0) begin
          if (p_err || p_ld) m_rd = p_rd;
          t = -1;
        end
      end
      if (rst_n) chk("rd", rd, m_rd);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] f, input logic [8:0] a, input logic [31:0] d);
    MemRead = r;
    MemWrite = w;
    Funct3 = f;
    addr = a;
    wd = d;
    req_valid = 1;
  endtask

  task automatic wait_ready(input string nm);
    logic acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
    end
    chk({nm, "_accept"}, acc, 1);
  endtask

  task automatic wait_resp(input string nm, input logic [31:0] erd, input logic eerr, input int elat);
    logic got = 0;
    int lat = 1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
      else lat++;
    end
    chk({nm, "_resp"}, got, 1);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_rd"}, rd, erd);
    chk({nm, "_err"}, err, eerr);
  endtask

  task automatic do_req(input string nm, input logic r, input logic w, input logic [2:0] f,
                        input logic [8:0] a, input logic [31:0] d, input logic [31:0] erd,
                        input logic eerr, input int elat);
    @(posedge clk);
    #1 drive(r, w, f, a, d);
    wait_ready(nm);
    @(posedge clk);
    #1 req_valid = 0;
    wait_resp(nm, erd, eerr, elat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int busy, c0;
    drive(1, 0, 3'b010, 9'h040, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_rst_ready", req_ready, 0);
    @(posedge clk);
    #1 begin rst_n = 1; req_valid = 0; end
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    chk("rd_after_rst", rd, 0);
    do_req("lb", 1, 0, 3'b000, 9'h042, 0, 32'hFFFFFF99, 0, 2);
    do_req("lbu", 1, 0, 3'b100, 9'h043, 0, 32'h00000088, 0, 2);
    do_req("lhu", 1, 0, 3'b101, 9'h042, 0, 32'h00008899, 0, 2);
    do_req("lh", 1, 0, 3'b001, 9'h040, 0, 32'hFFFFAABB, 0, 2);
    do_req("lw", 1, 0, 3'b010, 9'h040, 0, 32'h8899AABB, 0, 2);
    do_req("sb", 0, 1, 3'b000, 9'h041, 32'h123456CC, 32'h8899AABB, 0, 3);
    chk("sb_mem", ram[16], 32'h8899CCBB);
    do_req("lw_after_sb", 1, 0, 3'b010, 9'h040, 0, 32'h8899CCBB, 0, 2);
    do_req("sh_mis", 0, 1, 3'b001, 9'h043, 32'h0000FFFF, 32'h0, 1, 1);
    do_req("lw_mis", 1, 0, 3'b010, 9'h042, 0, 32'h0, 1, 1);
    do_req("rw_both", 1, 1, 3'b010, 9'h040, 0, 32'h0, 1, 1);
    do_req("rw_none", 0, 0, 3'b010, 9'h040, 0, 32'h0, 1, 1);
    do_req("ld_f011", 1, 0, 3'b011, 9'h040, 0, 32'h0, 1, 1);
    do_req("st_f100", 0, 1, 3'b100, 9'h040, 0, 32'h0, 1, 1);
    chk("err_mem", ram[16], 32'h8899CCBB);
    do_req("sw", 0, 1, 3'b010, 9'h044, 32'hDEADBEEF, 32'h0, 0, 2);
    chk("sw_mem", ram[17], 32'hDEADBEEF);
    do_req("sh", 0, 1, 3'b001, 9'h046, 32'h00001234, 32'h0, 0, 3);
    chk("sh_mem", ram[17], 32'h1234BEEF);
    // second request held while an SB read-modify-write is in flight
    @(posedge clk);
    #1 drive(0, 1, 3'b000, 9'h045, 32'h000000AB);
    c0 = resp_cnt;
    wait_ready("b2b_a");
    @(posedge clk);
    #1 drive(1, 0, 3'b010, 9'h044, 0);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) break;
      busy++;
    end
    chk("b2b_busy", busy, 3);
    @(posedge clk);
    #1 req_valid = 0;
    wait_resp("b2b_b", 32'h1234ABEF, 0, 2);
    repeat (3) @(negedge clk);
    chk("b2b_count", resp_cnt - c0, 2);
    // reset lands during the read phase of an SH
    @(posedge clk);
    #1 drive(0, 1, 3'b001, 9'h040, 32'h00005555);
    wait_ready("mid_rst");
    @(posedge clk);
    #1 begin req_valid = 0; rst_n = 0; end
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(negedge clk);
    chk("mid_rst_mem", ram[16], 32'h8899CCBB);
    chk("mid_rst_rd", rd, 0);
    do_req("lw_after_rst", 1, 0, 3'b010, 9'h040, 0, 32'h8899CCBB, 0, 2);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 128; w++)
      chk("ram_final", ram[w], {mbyte[w*4+3], mbyte[w*4+2], mbyte[w*4+1], mbyte[w*4]});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_align_rmw.md
Name: lsu_align_rmw

Overview:
- Load/store alignment unit between the execute-stage ALU result and the word-wide data memory.
- Decodes Funct3 and produces word-aligned memory accesses.
- Performs read-modify-write for sub-word stores, and byte-lane extract with sign/zero extension for loads.
- Stalls the pipeline through a valid/ready handshake and flags misaligned or illegal requests.

Parameters:
- DM_ADDRESS, 9, byte-address width into data memory
- DATA_W, 32, data word width (fixed 32; other values unsupported)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  unit can accept a request
- MemRead  in  1  load request, from control unit
- MemWrite  in  1  store request, from control unit
- Funct3  in  3  instruction bits 14:12
- addr  in  DM_ADDRESS  byte address, LSBs of ALU output
- wd  in  DATA_W  store data, rs2
- resp_valid  out  1  one-cycle completion pulse
- rd  out  DATA_W  load result, valid while resp_valid
- err  out  1  misaligned/illegal flag, valid while resp_valid
- mem_addr  out  DM_ADDRESS  word-aligned address, bits [1:0] always 0
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory full-word write strobe
- mem_wdata  out  DATA_W  word written to memory
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - resp_valid, err, mem_re, mem_we = 0; rd=0; mem_addr=0; mem_wdata=0.
  - req_ready=1 from the cycle after reset.
  - Reset mid-operation aborts it: no further mem_we, no resp_valid. A write already strobed in an earlier cycle stands.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR, ST_WR, RESP.
- req_ready=1 only in IDLE. A request is accepted on an edge where req_valid=1 in IDLE.
- On accept, the unit latches addr, wd, Funct3, MemRead and MemWrite. Inputs are ignored until the unit returns to IDLE.
- Request classification on accept:
  - err case (next state RESP, err=1, rd=0, no memory strobe):
    - MemRead=MemWrite=1, or both 0 with req_valid=1;
    - loads with Funct3 ∈ {011,110,111};
    - stores with Funct3 ∉ {000,001,010};
    - halfword access (LH/LHU/SH) with addr[0]=1;
    - word access (LW/SW) with addr[1:0]≠0.
  - Load, next state LD_WAIT: mem_re=1, mem_addr={addr[8:2],2'b00}.
  - SW, next state ST_WR: mem_we=1, mem_wdata=wd.
  - SB/SH, next state RMW_RD: mem_re=1.
- LD_WAIT to RESP. rd is registered from mem_rdata:
  - LB: sign-extend byte at lane addr[1:0].
  - LBU: zero-extend byte at lane addr[1:0].
  - LH: sign-extend halfword at addr[1].
  - LHU: zero-extend halfword at addr[1].
  - LW: full word.
- RMW_RD to RMW_WR: capture mem_rdata.
  - SB replaces lane addr[1:0] with wd[7:0].
  - SH replaces the half at addr[1] with wd[15:0].
- RMW_WR: mem_we=1 for exactly one cycle, mem_wdata=merged word, then RESP.
- ST_WR: mem_we=1 for one cycle, then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - err=0 on success.
  - rd holds the new value for loads and is unchanged for stores.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Single write port: mem_re and mem_we are never high in the same cycle.
- No back-to-back accept. The next request is accepted at the edge ending RESP+1, i.e. the first IDLE cycle.
- req_valid held high while busy is simply not accepted. The request is neither lost nor duplicated provided the source holds it until accepted.

Test Plan:
- Reset with req_valid=1 held → all outputs 0, req_ready=1 after release, no mem strobes during reset.
- Memory word 0x8899AABB at byte 0x40:
  - LB addr 0x42 → rd=0xFFFFFF99, err=0;
  - LBU addr 0x43 → rd=0x00000088;
  - LHU addr 0x42 → rd=0x00008899;
  - LW addr 0x40 → rd=0x8899AABB, resp_valid 2 cycles after accept.
- SB wd=0x123456CC to addr 0x41 over word 0x8899AABB → mem_re one cycle, then mem_we one cycle with mem_wdata=0x8899CCBB, resp_valid at accept+3; following LW returns 0x8899CCBB.
- Misaligned requests:
  - SH addr 0x43 → resp_valid with err=1 next cycle, mem_re=mem_we=0 throughout;
  - LW addr 0x42 → err=1, rd=0;
  - MemRead=MemWrite=1 → err=1.
- Second request presented during the RMW of an SB → req_ready=0 for 3 cycles, second request accepted in the first IDLE cycle, exactly one completion per request.
- rst_n low during RMW_RD of an SH → no mem_we issued, state IDLE, memory word unchanged; subsequent LW succeeds.
